// File: rtl/peb_pkg.sv
// Shared definitions for the peripheral expansion bus merger: wishbone FSM states,
// the local-register slot index and status bit positions.
package peb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } wb_state_t;

    localparam logic [3:0] LOCAL_SLOT = 4'd15;

    localparam int unsigned ST_CONFLICT   = 0;
    localparam int unsigned ST_WBTIMEOUT  = 1;
    localparam int unsigned ST_RDYTIMEOUT = 2;

endpackage

// File: rtl/peb_bus_watchdog.sv
// Ready watchdog: forces the merged ready high after READY_TIMEOUT CPU ticks of
// continuous not-ready inside a memory cycle, until memen falls.
module peb_bus_watchdog #(
    parameter int unsigned READY_TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cpu_clk_en,
    input  logic i_memen,
    input  logic i_rdy_and,
    output logic o_force,
    output logic o_timeout
);

    localparam int unsigned CW = $clog2(READY_TIMEOUT + 1);

    logic [CW-1:0] r_cnt;
    logic          r_force;
    logic          w_expire;

    assign w_expire = i_memen & ~i_rdy_and & i_cpu_clk_en & ~r_force
                    & (r_cnt == CW'(READY_TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_force <= 1'b0;
        end else if (!i_memen) begin
            r_cnt   <= '0;
            r_force <= 1'b0;
        end else if (i_rdy_and) begin
            r_cnt <= '0;
        end else if (i_cpu_clk_en && !r_force) begin
            if (w_expire) r_force <= 1'b1;
            else          r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_force   = r_force;
    assign o_timeout = w_expire;

endmodule

// File: rtl/peb_bus.sv
// Expansion-bus merger: combines card q/cruin/ready, detects read conflicts and
// bridges wishbone to per-slot cards. Ready watchdog enabled by PEB_BUS_WATCHDOG_EN.
module peb_bus
    import peb_pkg::*;
#(
    parameter int unsigned NSLOTS        = 4,
    parameter int unsigned WB_TIMEOUT    = 255,
    parameter int unsigned READY_TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_clk_en,
    input  logic                  memen,
    input  logic                  dbin,
    input  logic [0:8*NSLOTS-1]   slot_q,
    input  logic [NSLOTS-1:0]     slot_q_select,
    input  logic [NSLOTS-1:0]     slot_cruin,
    input  logic [NSLOTS-1:0]     slot_cru_select,
    input  logic [NSLOTS-1:0]     slot_ready,
    output logic [7:0]            q,
    output logic                  cruin,
    output logic                  ready,
    input  logic [0:22]           wb_adr_i,
    input  logic [7:0]            wb_dat_i,
    output logic [7:0]            wb_dat_o,
    input  logic                  wb_we_i,
    input  logic                  wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic [NSLOTS-1:0]     slot_wb_stb,
    input  logic [0:8*NSLOTS-1]   slot_wb_dat,
    input  logic [NSLOTS-1:0]     slot_wb_ack,
    output logic                  irq_err
);

    localparam int unsigned TW = $clog2(WB_TIMEOUT + 1);

    wb_state_t       r_state, w_next;
    logic [3:0]      r_idx;
    logic            r_is_slot, r_is_local;
    logic [TW-1:0]   r_tcnt;
    logic [7:0]      r_dat, r_ccount;
    logic            r_ack, r_conflict, r_wbto, r_rdyto;

    logic [7:0]        w_q, w_sel_dat, w_loc_rd, w_status;
    logic              w_cruin, w_rdy_and, w_multi, w_seen, w_sel_ack;
    logic [NSLOTS-1:0] w_stb;
    logic [3:0]        w_adr_slot;
    logic              w_base, w_dec_slot, w_dec_local, w_conflict_ev;
    logic              w_ack_take, w_to_fire, w_loc_acc, w_wr_loc, w_clr0, w_clr1;
    logic              w_rdy_force, w_rdyto_set, w_unused;

    // Card merge; a second selected card marks a multi-drive condition.
    always_comb begin
        w_q       = '0;
        w_cruin   = 1'b0;
        w_rdy_and = 1'b1;
        w_multi   = 1'b0;
        w_seen    = 1'b0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            if (slot_q_select[i]) begin
                w_q     = w_q | slot_q[8*i +: 8];
                w_multi = w_multi | w_seen;
                w_seen  = 1'b1;
            end
            w_cruin   = w_cruin | (slot_cruin[i] & slot_cru_select[i]);
            w_rdy_and = w_rdy_and & slot_ready[i];
        end
    end

    assign w_conflict_ev = memen & dbin & w_multi;

    always_comb begin
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        w_stb     = '0;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            if (r_is_slot && (4'(i) == r_idx)) begin
                w_sel_ack = slot_wb_ack[i];
                w_sel_dat = slot_wb_dat[8*i +: 8];
                w_stb[i]  = (r_state == ST_WAIT) & wb_stb_i;
            end
        end
    end

    assign w_adr_slot  = wb_adr_i[3:6];
    assign w_base      = (wb_adr_i[0:2] == 3'b000);
    assign w_dec_slot  = w_base && (32'(w_adr_slot) < NSLOTS);
    assign w_dec_local = w_base && (w_adr_slot == LOCAL_SLOT);

    always_comb begin
        w_next     = r_state;
        w_ack_take = 1'b0;
        w_to_fire  = 1'b0;
        w_loc_acc  = 1'b0;
        case (r_state)
            ST_IDLE: if (wb_cyc_i && wb_stb_i) w_next = ST_WAIT;
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    w_next = ST_IDLE;
                end else if (!r_is_slot) begin
                    w_next    = ST_DONE;
                    w_loc_acc = 1'b1;
                end else if (w_sel_ack) begin
                    w_next     = ST_DONE;
                    w_ack_take = 1'b1;
                end else if (r_tcnt == TW'(WB_TIMEOUT)) begin
                    w_next    = ST_DONE;
                    w_to_fire = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    assign w_status = {5'b0, r_rdyto, r_wbto, r_conflict};
    assign w_loc_rd = !r_is_local ? 8'h00 : (wb_adr_i[22] ? r_ccount : w_status);
    assign w_wr_loc = w_loc_acc & r_is_local & wb_we_i;
    assign w_clr0   = w_wr_loc & ~wb_adr_i[22];
    assign w_clr1   = w_wr_loc & wb_adr_i[22];

    // Sticky bits: a set event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_idx      <= '0;
            r_is_slot  <= 1'b0;
            r_is_local <= 1'b0;
            r_tcnt     <= '0;
            r_ccount   <= '0;
            r_conflict <= 1'b0;
            r_wbto     <= 1'b0;
            r_rdyto    <= 1'b0;
        end else begin
            r_ack <= (r_state == ST_DONE);
            if (r_state == ST_IDLE && wb_cyc_i && wb_stb_i) begin
                r_idx      <= w_adr_slot;
                r_is_slot  <= w_dec_slot;
                r_is_local <= w_dec_local;
                r_tcnt     <= '0;
            end else if (r_state == ST_WAIT && r_is_slot && w_next == ST_WAIT) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
            if (w_ack_take)     r_dat <= w_sel_dat;
            else if (w_to_fire) r_dat <= 8'hFF;
            else if (w_loc_acc) r_dat <= w_loc_rd;
            if (w_conflict_ev) begin
                if (r_ccount != 8'hFF) r_ccount <= r_ccount + 1'b1;
            end else if (w_clr1) begin
                r_ccount <= '0;
            end
            r_conflict <= w_conflict_ev | (r_conflict & ~(w_clr0 & wb_dat_i[ST_CONFLICT]));
            r_wbto     <= w_to_fire     | (r_wbto     & ~(w_clr0 & wb_dat_i[ST_WBTIMEOUT]));
            r_rdyto    <= w_rdyto_set   | (r_rdyto    & ~(w_clr0 & wb_dat_i[ST_RDYTIMEOUT]));
        end
    end

`ifdef PEB_BUS_WATCHDOG_EN
    peb_bus_watchdog #(
        .READY_TIMEOUT(READY_TIMEOUT)
    ) u_watchdog (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_cpu_clk_en(cpu_clk_en),
        .i_memen     (memen),
        .i_rdy_and   (w_rdy_and),
        .o_force     (w_rdy_force),
        .o_timeout   (w_rdyto_set)
    );
    assign w_unused = ^{wb_sel_i, wb_adr_i[7:21], wb_dat_i[7:3]};
`else
    assign w_rdy_force = 1'b0;
    assign w_rdyto_set = 1'b0;
    assign w_unused    = ^{cpu_clk_en, wb_sel_i, wb_adr_i[7:21], wb_dat_i[7:3], 32'(READY_TIMEOUT)};
`endif

    assign q           = w_q;
    assign cruin       = w_cruin;
    assign ready       = w_rdy_and | w_rdy_force;
    assign wb_dat_o    = r_dat;
    assign wb_ack_o    = r_ack;
    assign slot_wb_stb = w_stb;
    assign irq_err     = r_conflict | r_wbto | r_rdyto;

endmodule
